// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - widths, entry types and tag-match helpers for the reservation station
package reservation_station_pkg;

    localparam int DataLength   = 32;
    localparam int PcLength     = 32;
    localparam int OpcodeLength = 6;

    localparam logic [OpcodeLength:0] OpAdd  = 7'b0110011;
    localparam logic [OpcodeLength:0] OpAddi = 7'b0010011;

    typedef struct packed {
        logic [DataLength-1:0] v;
        logic [PcLength-1:0]   q;
    } operand_t;

    typedef struct packed {
        logic [OpcodeLength:0] op;
        logic [PcLength-1:0]   pc;
        logic [DataLength-1:0] imm;
        operand_t              o1;
        operand_t              o2;
    } entry_t;

    // A tag is the producer pc with bit 0 forced high, so tag 0 can never match.
    function automatic logic tag_hit(input logic fin, input logic [PcLength-1:0] pc,
                                     input logic [PcLength-1:0] tag);
        return fin && ((pc | PcLength'(1)) == tag);
    endfunction

    // Rob commit is applied last so it wins when both broadcasts hit one operand.
    function automatic operand_t wake(input operand_t o,
                                      input logic rob_fin, input logic [PcLength-1:0] rob_pc,
                                      input logic [DataLength-1:0] rob_data,
                                      input logic alu_fin, input logic [PcLength-1:0] alu_pc,
                                      input logic [DataLength-1:0] alu_data);
        operand_t r;
        r = o;
        if (tag_hit(alu_fin, alu_pc, o.q)) begin
            r.v = alu_data;
            r.q = '0;
        end
        if (tag_hit(rob_fin, rob_pc, o.q)) begin
            r.v = rob_data;
            r.q = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, commit, ALU bypass and issue bus of the reservation station
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic                  is_empty_from_rob;
    logic                  is_sl_from_rob;
    logic                  is_exception_from_rob;
    logic [OpcodeLength:0] op_from_rob;
    logic [PcLength-1:0]   pc_from_rob;
    logic [DataLength-1:0] v1_from_rob;
    logic [DataLength-1:0] v2_from_rob;
    logic [PcLength-1:0]   q1_from_rob;
    logic [PcLength-1:0]   q2_from_rob;
    logic [DataLength-1:0] imm_from_rob;
    logic                  is_finish_from_rob;
    logic [PcLength-1:0]   commit_pc_from_rob;
    logic [DataLength-1:0] commit_data_from_rob;
    logic                  is_finish_from_alu;
    logic [PcLength-1:0]   pc_from_alu;
    logic [DataLength-1:0] data_from_alu;
    logic                  is_stall_to_rob;
    logic                  is_valid_to_alu;
    logic [OpcodeLength:0] op_to_alu;
    logic [PcLength-1:0]   pc_to_alu;
    logic [DataLength-1:0] v1_to_alu;
    logic [DataLength-1:0] v2_to_alu;
    logic [DataLength-1:0] imm_to_alu;

    modport master (
        output is_empty_from_rob, is_sl_from_rob, is_exception_from_rob, op_from_rob,
               pc_from_rob, v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob, imm_from_rob,
               is_finish_from_rob, commit_pc_from_rob, commit_data_from_rob,
               is_finish_from_alu, pc_from_alu, data_from_alu,
        input  is_stall_to_rob, is_valid_to_alu, op_to_alu, pc_to_alu, v1_to_alu,
               v2_to_alu, imm_to_alu
    );

    modport slave (
        input  is_empty_from_rob, is_sl_from_rob, is_exception_from_rob, op_from_rob,
               pc_from_rob, v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob, imm_from_rob,
               is_finish_from_rob, commit_pc_from_rob, commit_data_from_rob,
               is_finish_from_alu, pc_from_alu, data_from_alu,
        output is_stall_to_rob, is_valid_to_alu, op_to_alu, pc_to_alu, v1_to_alu,
               v2_to_alu, imm_to_alu
    );

endinterface

// File: rtl/rs_pick_lowest.sv
// rtl/rs_pick_lowest.sv - lowest-index priority encoder with found flag
module rs_pick_lowest #(
    parameter int Width    = 8,
    parameter int IdxWidth = 3
) (
    input  logic [Width-1:0]    req,
    output logic [IdxWidth-1:0] idx,
    output logic                found
);

    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IdxWidth'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - integer-op reservation station; RS_ALU_BYPASS_EN adds ALU-result wakeup
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RsDepth   = 8,
    parameter int IdxLength = 2
) (
    input logic                  clk,
    input logic                  rst,
    reservation_station_if.slave bus
);

    logic [RsDepth-1:0]    busy;
    entry_t                ent   [RsDepth];
    operand_t              woke1 [RsDepth];
    operand_t              woke2 [RsDepth];
    logic [RsDepth-1:0]    free_vec;
    logic [RsDepth-1:0]    ready_vec;
    logic [RsDepth-1:0]    next_busy;
    logic [IdxLength:0]    alloc_idx;
    logic [IdxLength:0]    sel_idx;
    logic                  alloc_found;
    logic                  sel_found;
    logic                  accept;
    logic                  do_accept;
    entry_t                incoming;
    logic                  alu_fin;
    logic [PcLength-1:0]   alu_pc;
    logic [DataLength-1:0] alu_data;

`ifdef RS_ALU_BYPASS_EN
    assign alu_fin  = bus.is_finish_from_alu;
    assign alu_pc   = bus.pc_from_alu;
    assign alu_data = bus.data_from_alu;
`else
    assign alu_fin  = 1'b0;
    assign alu_pc   = '0;
    assign alu_data = '0;
    logic unused_alu;
    assign unused_alu = ^{bus.is_finish_from_alu, bus.pc_from_alu, bus.data_from_alu};
`endif

    assign accept    = !bus.is_empty_from_rob && !bus.is_sl_from_rob && !bus.is_exception_from_rob;
    assign do_accept = accept && alloc_found;

    always_comb begin
        for (int i = 0; i < RsDepth; i++) begin
            free_vec[i]  = !busy[i];
            ready_vec[i] = busy[i] && (ent[i].o1.q == '0) && (ent[i].o2.q == '0);
            woke1[i]     = wake(ent[i].o1, bus.is_finish_from_rob, bus.commit_pc_from_rob,
                                bus.commit_data_from_rob, alu_fin, alu_pc, alu_data);
            woke2[i]     = wake(ent[i].o2, bus.is_finish_from_rob, bus.commit_pc_from_rob,
                                bus.commit_data_from_rob, alu_fin, alu_pc, alu_data);
        end
    end

    // Incoming operands snoop the same-cycle broadcasts so they never miss a wakeup.
    always_comb begin
        incoming.op  = bus.op_from_rob;
        incoming.pc  = bus.pc_from_rob;
        incoming.imm = bus.imm_from_rob;
        incoming.o1  = wake('{v: bus.v1_from_rob, q: bus.q1_from_rob}, bus.is_finish_from_rob,
                            bus.commit_pc_from_rob, bus.commit_data_from_rob,
                            alu_fin, alu_pc, alu_data);
        incoming.o2  = wake('{v: bus.v2_from_rob, q: bus.q2_from_rob}, bus.is_finish_from_rob,
                            bus.commit_pc_from_rob, bus.commit_data_from_rob,
                            alu_fin, alu_pc, alu_data);
    end

    always_comb begin
        next_busy = busy;
        if (sel_found) next_busy[sel_idx] = 1'b0;
        if (do_accept) next_busy[alloc_idx] = 1'b1;
    end

    rs_pick_lowest #(.Width(RsDepth), .IdxWidth(IdxLength + 1)) u_pick_free (
        .req   (free_vec),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    rs_pick_lowest #(.Width(RsDepth), .IdxWidth(IdxLength + 1)) u_pick_ready (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy                <= '0;
            for (int i = 0; i < RsDepth; i++) ent[i] <= '0;
            bus.is_stall_to_rob <= 1'b0;
            bus.is_valid_to_alu <= 1'b0;
            bus.op_to_alu       <= '0;
            bus.pc_to_alu       <= '0;
            bus.v1_to_alu       <= '0;
            bus.v2_to_alu       <= '0;
            bus.imm_to_alu      <= '0;
        end else if (bus.is_exception_from_rob) begin
            busy                <= '0;
            bus.is_stall_to_rob <= 1'b0;
            bus.is_valid_to_alu <= 1'b0;
        end else begin
            bus.is_valid_to_alu <= sel_found;
            if (sel_found) begin
                bus.op_to_alu  <= ent[sel_idx].op;
                bus.pc_to_alu  <= ent[sel_idx].pc;
                bus.v1_to_alu  <= ent[sel_idx].o1.v;
                bus.v2_to_alu  <= ent[sel_idx].o2.v;
                bus.imm_to_alu <= ent[sel_idx].imm;
            end
            for (int i = 0; i < RsDepth; i++) begin
                if (busy[i]) begin
                    ent[i].o1 <= woke1[i];
                    ent[i].o2 <= woke2[i];
                end
            end
            if (do_accept) ent[alloc_idx] <= incoming;
            busy <= next_busy;
            // One slot stays in reserve for the dispatch rob has already registered.
            bus.is_stall_to_rob <= ($countones(next_busy) >= RsDepth - 1);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(accept && !alloc_found));

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized and directed self-checking bench for reservation_station
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int RsDepth = 8;

    logic clk = 1'b0;
    logic rst;

    reservation_station_if bus ();

    reservation_station #(.RsDepth(RsDepth), .IdxLength(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          busy;
        logic [6:0]  op;
        logic [31:0] pc, imm, v1, v2, q1, q2;
    } m_ent_t;

    m_ent_t      m [RsDepth];
    bit          exp_valid, exp_stall;
    logic [6:0]  exp_op;
    logic [31:0] exp_pc, exp_v1, exp_v2, exp_imm;

    function automatic bit hits(bit fin, logic [31:0] pc, logic [31:0] tag);
        return fin && tag[0] && (tag[31:1] == pc[31:1]);
    endfunction

    task automatic snoop(inout logic [31:0] v, inout logic [31:0] q);
        logic [31:0] q0;
        q0 = q;
`ifdef RS_ALU_BYPASS_EN
        if (hits(bus.is_finish_from_alu, bus.pc_from_alu, q0)) begin
            v = bus.data_from_alu;
            q = 0;
        end
`endif
        if (hits(bus.is_finish_from_rob, bus.commit_pc_from_rob, q0)) begin
            v = bus.commit_data_from_rob;
            q = 0;
        end
    endtask

    task automatic model_step();
        int sel;
        int slot;
        int n;
        sel  = -1;
        slot = -1;
        n    = 0;
        if (bus.is_exception_from_rob) begin
            for (int i = 0; i < RsDepth; i++) m[i].busy = 0;
            exp_valid = 0;
            exp_stall = 0;
            return;
        end
        for (int i = 0; i < RsDepth; i++) begin
            if (sel < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) sel = i;
            if (slot < 0 && !m[i].busy) slot = i;
        end
        exp_valid = (sel >= 0);
        if (exp_valid) begin
            exp_op  = m[sel].op;
            exp_pc  = m[sel].pc;
            exp_v1  = m[sel].v1;
            exp_v2  = m[sel].v2;
            exp_imm = m[sel].imm;
            m[sel].busy = 0;
        end
        for (int i = 0; i < RsDepth; i++) begin
            if (m[i].busy) begin
                snoop(m[i].v1, m[i].q1);
                snoop(m[i].v2, m[i].q2);
            end
        end
        if (!bus.is_empty_from_rob && !bus.is_sl_from_rob && slot >= 0) begin
            m[slot].busy = 1;
            m[slot].op   = bus.op_from_rob;
            m[slot].pc   = bus.pc_from_rob;
            m[slot].imm  = bus.imm_from_rob;
            m[slot].v1   = bus.v1_from_rob;
            m[slot].v2   = bus.v2_from_rob;
            m[slot].q1   = bus.q1_from_rob;
            m[slot].q2   = bus.q2_from_rob;
            snoop(m[slot].v1, m[slot].q1);
            snoop(m[slot].v2, m[slot].q2);
        end
        for (int i = 0; i < RsDepth; i++) if (m[i].busy) n++;
        exp_stall = (n >= RsDepth - 1);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", bus.is_valid_to_alu, exp_valid);
        chk("stall", bus.is_stall_to_rob, exp_stall);
        if (exp_valid) begin
            chk("op", bus.op_to_alu, exp_op);
            chk("pc", bus.pc_to_alu, exp_pc);
            chk("v1", bus.v1_to_alu, exp_v1);
            chk("v2", bus.v2_to_alu, exp_v2);
            chk("imm", bus.imm_to_alu, exp_imm);
        end
    endtask

    task automatic idle();
        bus.is_empty_from_rob     = 1;
        bus.is_sl_from_rob        = 0;
        bus.is_exception_from_rob = 0;
        bus.op_from_rob           = 0;
        bus.pc_from_rob           = 0;
        bus.v1_from_rob           = 0;
        bus.v2_from_rob           = 0;
        bus.q1_from_rob           = 0;
        bus.q2_from_rob           = 0;
        bus.imm_from_rob          = 0;
        bus.is_finish_from_rob    = 0;
        bus.commit_pc_from_rob    = 0;
        bus.commit_data_from_rob  = 0;
        bus.is_finish_from_alu    = 0;
        bus.pc_from_alu           = 0;
        bus.data_from_alu         = 0;
    endtask

    task automatic disp(logic [6:0] op, logic [31:0] pc, logic [31:0] v1, logic [31:0] v2,
                        logic [31:0] q1, logic [31:0] q2, logic [31:0] imm);
        bus.is_empty_from_rob = 0;
        bus.op_from_rob       = op;
        bus.pc_from_rob       = pc;
        bus.v1_from_rob       = v1;
        bus.v2_from_rob       = v2;
        bus.q1_from_rob       = q1;
        bus.q2_from_rob       = q2;
        bus.imm_from_rob      = imm;
    endtask

    task automatic commit(logic [31:0] pc, logic [31:0] data);
        bus.is_finish_from_rob   = 1;
        bus.commit_pc_from_rob   = pc;
        bus.commit_data_from_rob = data;
    endtask

    function automatic logic [31:0] rand_tag();
        if ($urandom_range(0, 1) == 0) return 32'h0;
        return (32'h100 + 32'(2 * $urandom_range(0, 7))) | 32'h1;
    endfunction

    function automatic logic [31:0] rand_prod_pc();
        return 32'h100 + 32'(2 * $urandom_range(0, 7)) + 32'($urandom_range(0, 1));
    endfunction

    initial begin
        bit has_free;
        idle();
        rst = 1;
        for (int i = 0; i < RsDepth; i++) m[i].busy = 0;
        #2;
        chk("rst_valid", bus.is_valid_to_alu, 0);
        chk("rst_stall", bus.is_stall_to_rob, 0);
        chk("rst_pc", bus.pc_to_alu, 0);
        chk("rst_v1", bus.v1_to_alu, 0);
        @(posedge clk);
        #1;
        rst = 0;

        // ready instruction issues one edge after accept
        disp(OpAddi, 32'h10, 32'd5, 32'd0, 32'h0, 32'h0, 32'd3);
        step();
        chk("addi_not_yet", bus.is_valid_to_alu, 0);
        idle();
        step();
        chk("addi_valid", bus.is_valid_to_alu, 1);
        chk("addi_pc", bus.pc_to_alu, 32'h10);
        chk("addi_v1", bus.v1_to_alu, 32'd5);
        chk("addi_imm", bus.imm_to_alu, 32'd3);
        step();
        chk("addi_pulse", bus.is_valid_to_alu, 0);

        // dependency resolved by commit broadcast
        disp(OpAdd, 32'h24, 32'd0, 32'd2, 32'h21, 32'h0, 32'd0);
        step();
        idle();
        step();
        chk("dep_wait", bus.is_valid_to_alu, 0);
        commit(32'h20, 32'h77);
        step();
        chk("dep_wake_edge", bus.is_valid_to_alu, 0);
        idle();
        step();
        chk("dep_valid", bus.is_valid_to_alu, 1);
        chk("dep_v1", bus.v1_to_alu, 32'h77);

        // same-edge capture
        disp(OpAdd, 32'h34, 32'd1, 32'd0, 32'h0, 32'h31, 32'd0);
        commit(32'h30, 32'd9);
        step();
        idle();
        step();
        chk("cap_valid", bus.is_valid_to_alu, 1);
        chk("cap_v2", bus.v2_to_alu, 32'd9);

        // fill to the stall threshold plus the in-flight slot
        for (int i = 0; i < 8; i++) begin
            idle();
            disp(OpAdd, 32'h60 + 32'(4 * i), 32'd0, 32'(i), 32'h51, 32'h0, 32'd0);
            step();
            if (i == 5) chk("fill6_stall", bus.is_stall_to_rob, 0);
            if (i == 6) chk("fill7_stall", bus.is_stall_to_rob, 1);
            if (i == 7) chk("fill8_stall", bus.is_stall_to_rob, 1);
        end
        idle();
        commit(32'h50, 32'h5);
        step();
        idle();
        step();
        chk("drain_first_pc", bus.pc_to_alu, 32'h60);
        chk("drain_first_stall", bus.is_stall_to_rob, 1);
        step();
        chk("drain_second_pc", bus.pc_to_alu, 32'h64);
        chk("drain_stall_clear", bus.is_stall_to_rob, 0);
        for (int i = 0; i < 6; i++) step();

        // flush
        for (int i = 0; i < 4; i++) begin
            idle();
            disp(OpAdd, 32'hA0 + 32'(4 * i), 32'd0, 32'd0, 32'h71, 32'h0, 32'd0);
            step();
        end
        idle();
        bus.is_exception_from_rob = 1;
        step();
        chk("flush_valid", bus.is_valid_to_alu, 0);
        chk("flush_stall", bus.is_stall_to_rob, 0);
        idle();
        commit(32'h70, 32'd1);
        step();
        idle();
        step();
        chk("flush_stale", bus.is_valid_to_alu, 0);
        disp(OpAddi, 32'h80, 32'd4, 32'd0, 32'h0, 32'h0, 32'd1);
        step();
        idle();
        step();
        chk("post_flush_valid", bus.is_valid_to_alu, 1);
        chk("post_flush_pc", bus.pc_to_alu, 32'h80);

        // ALU result broadcast
        disp(OpAdd, 32'h90, 32'd0, 32'd0, 32'h41, 32'h0, 32'd0);
        step();
        idle();
        bus.is_finish_from_alu = 1;
        bus.pc_from_alu        = 32'h40;
        bus.data_from_alu      = 32'hAB;
        step();
        idle();
        step();
`ifdef RS_ALU_BYPASS_EN
        chk("byp_valid", bus.is_valid_to_alu, 1);
        chk("byp_v1", bus.v1_to_alu, 32'hAB);
`else
        chk("nobyp_wait", bus.is_valid_to_alu, 0);
        commit(32'h40, 32'hCD);
        step();
        idle();
        step();
        chk("nobyp_valid", bus.is_valid_to_alu, 1);
        chk("nobyp_v1", bus.v1_to_alu, 32'hCD);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            has_free = 0;
            for (int i = 0; i < RsDepth; i++) if (!m[i].busy) has_free = 1;
            if (has_free && $urandom_range(0, 3) != 0) begin
                disp(($urandom_range(0, 1) == 0) ? OpAdd : OpAddi,
                     32'h200 + 32'(4 * $urandom_range(0, 63)), $urandom, $urandom,
                     rand_tag(), rand_tag(), $urandom);
                bus.is_sl_from_rob = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 2) == 0) commit(rand_prod_pc(), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.is_finish_from_alu = 1;
                bus.pc_from_alu        = rand_prod_pc();
                bus.data_from_alu      = $urandom;
            end
            if ($urandom_range(0, 99) == 0) bus.is_exception_from_rob = 1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
